// File: rtl/high_speed_in_pkg.sv
// Shared definitions for the high-speed input arbiter: FSM state encoding
// and the default release-timeout limit.
package high_speed_in_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_GRANT   = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  localparam int DEFAULT_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/double_latching_barrier.sv
// Two-flop synchronizer for one asynchronous level signal into clk.
// The enable gates both stages; tie it high for a plain synchronizer.
module double_latching_barrier (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic d,
  output logic q
);

  logic stage1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage1 <= 1'b0;
      q      <= 1'b0;
    end else if (enable) begin
      stage1 <= d;
      q      <= stage1;
    end
  end

endmodule

// File: rtl/rr_priority_picker.sv
// Combinational round-robin search: finds the first set request bit
// starting at last+1 and wrapping around.
module rr_priority_picker #(
  parameter int NUM_CHANNELS = 4,
  parameter int SEL_WIDTH    = $clog2(NUM_CHANNELS)
) (
  input  logic [NUM_CHANNELS-1:0] req,
  input  logic [SEL_WIDTH-1:0]    last,
  output logic                    found,
  output logic [SEL_WIDTH-1:0]    index
);

  int pos;

  // Walk from the farthest offset to the nearest so the nearest hit wins.
  always_comb begin
    found = 1'b0;
    index = '0;
    pos   = 0;
    for (int k = NUM_CHANNELS; k >= 1; k--) begin
      pos = (int'(last) + k) % NUM_CHANNELS;
      if (req[pos]) begin
        found = 1'b1;
        index = SEL_WIDTH'(pos);
      end
    end
  end

endmodule

// File: rtl/high_speed_in_arbiter.sv
// Round-robin arbiter sharing one consumer between async 4-phase input links.
// Define HIGH_SPEED_IN_ARBITER_TIMEOUT_EN to enable the release timeout.
module high_speed_in_arbiter
  import high_speed_in_pkg::*;
#(
  parameter int NUM_CHANNELS   = 4,
  parameter int SEL_WIDTH      = $clog2(NUM_CHANNELS),
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    data_required,
  input  logic [NUM_CHANNELS-1:0] request,
  output logic [NUM_CHANNELS-1:0] acknowledge,
  output logic                    data_available,
  output logic [SEL_WIDTH-1:0]    selected,
  output logic                    timeout_error
);

  localparam logic [SEL_WIDTH-1:0] LAST_RESET = SEL_WIDTH'(NUM_CHANNELS - 1);

  if (NUM_CHANNELS < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("high_speed_in_arbiter: NUM_CHANNELS must be >= 2 and TIMEOUT_CYCLES >= 1");
  end

  logic [NUM_CHANNELS-1:0] req_sync;
  logic [NUM_CHANNELS-1:0] grant_onehot;
  logic [1:0]              state;
  logic [SEL_WIDTH-1:0]    last;
  logic [SEL_WIDTH-1:0]    pick_index;
  logic                    pick_found;
  logic                    release_expired;

  for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_sync
    double_latching_barrier u_sync (
      .clk    (clk),
      .rst    (rst),
      .enable (1'b1),
      .d      (request[gi]),
      .q      (req_sync[gi])
    );
  end

  rr_priority_picker #(
    .NUM_CHANNELS (NUM_CHANNELS),
    .SEL_WIDTH    (SEL_WIDTH)
  ) u_picker (
    .req   (req_sync),
    .last  (last),
    .found (pick_found),
    .index (pick_index)
  );

  always_comb begin
    grant_onehot           = '0;
    grant_onehot[selected] = 1'b1;
  end

  assign data_available = (state == ST_GRANT) && data_required;

`ifdef HIGH_SPEED_IN_ARBITER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] release_count;
  logic [CNT_W-1:0] release_count_next;

  assign release_count_next = release_count + CNT_W'(1);
  assign release_expired    = (state == ST_RELEASE) &&
                              (release_count_next == CNT_W'(TIMEOUT_CYCLES));

  // The count is cleared while in GRANT so it starts at zero on entry to RELEASE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      release_count <= '0;
      timeout_error <= 1'b0;
    end else begin
      if (state == ST_GRANT) begin
        release_count <= '0;
      end else if (state == ST_RELEASE) begin
        release_count <= release_count_next;
      end
      if (release_expired && req_sync[selected]) begin
        timeout_error <= 1'b1;
      end
    end
  end
`else
  assign release_expired = 1'b0;
  assign timeout_error   = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      selected    <= '0;
      last        <= LAST_RESET;
      acknowledge <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_found) begin
            selected <= pick_index;
            state    <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          // Without a consumer read the grant is held; no re-arbitration.
          if (data_required) begin
            acknowledge <= grant_onehot;
            last        <= selected;
            state       <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (!req_sync[selected] || release_expired) begin
            acknowledge <= '0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_high_speed_in_arbiter.sv
// Directed self-checking bench for high_speed_in_arbiter (4 links, timeout 8).
// Timeout behaviour checked follows HIGH_SPEED_IN_ARBITER_TIMEOUT_EN.
module tb_high_speed_in_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       data_required;
  logic [3:0] request;
  logic [3:0] acknowledge;
  logic       data_available;
  logic [1:0] selected;
  logic       timeout_error;

  int n_compared   = 0;
  int n_mismatched = 0;

  always #5 clk = ~clk;

  high_speed_in_arbiter #(
    .NUM_CHANNELS   (4),
    .SEL_WIDTH      (2),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .data_required  (data_required),
    .request        (request),
    .acknowledge    (acknowledge),
    .data_available (data_available),
    .selected       (selected),
    .timeout_error  (timeout_error)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    request       = 4'b0000;
    data_required = 1'b0;
    tick(2);
    rst = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    request       = 4'b0000;
    data_required = 1'b0;
    tick(2);
    check("reset_ack", 32'(acknowledge), 32'h0);
    check("reset_da", 32'(data_available), 32'h0);
    check("reset_sel", 32'(selected), 32'h0);
    check("reset_terr", 32'(timeout_error), 32'h0);
    rst = 1'b0;

    // Single link 2: read 3 cycles after request, ack next, drop 3 cycles after fall
    request       = 4'b0100;
    data_required = 1'b1;
    tick(2);
    check("s1_da_early", 32'(data_available), 32'h0);
    tick(1);
    check("s1_da", 32'(data_available), 32'h1);
    check("s1_sel", 32'(selected), 32'h2);
    check("s1_ack_before", 32'(acknowledge), 32'h0);
    tick(1);
    check("s1_ack_high", 32'(acknowledge), 32'h4);
    check("s1_da_release", 32'(data_available), 32'h0);
    request = 4'b0000;
    tick(2);
    check("s1_ack_held", 32'(acknowledge), 32'h4);
    tick(1);
    check("s1_ack_low", 32'(acknowledge), 32'h0);

    // All four links requesting: round-robin 0,1,2,3,0
    do_reset();
    request       = 4'b1111;
    data_required = 1'b1;
    for (int g = 0; g < 5; g++) begin
      int exp_idx;
      int waited;
      exp_idx = g % 4;
      waited  = 0;
      while (acknowledge == 4'b0000 && waited < 20) begin
        tick(1);
        waited++;
      end
      if (waited >= 20) check("s2_ack_rise_bound", 32'h0, 32'h1);
      check($sformatf("s2_grant%0d_ack", g), 32'(acknowledge), 32'(4'b0001 << exp_idx));
      check($sformatf("s2_grant%0d_sel", g), 32'(selected), 32'(exp_idx));
      request[exp_idx] = 1'b0;
      waited = 0;
      while (acknowledge != 4'b0000 && waited < 20) begin
        check("s2_onehot", 32'($onehot0(acknowledge)), 32'h1);
        tick(1);
        waited++;
      end
      if (waited >= 20) check("s2_ack_fall_bound", 32'h0, 32'h1);
      request[exp_idx] = 1'b1;
    end

    // Consumer stalls 10 cycles in GRANT, then reads once
    do_reset();
    request = 4'b0010;
    tick(3);
    for (int i = 0; i < 10; i++) begin
      check("s3_hold_sel", 32'(selected), 32'h1);
      check("s3_hold_da", 32'(data_available), 32'h0);
      check("s3_hold_ack", 32'(acknowledge), 32'h0);
      tick(1);
    end
    data_required = 1'b1;
    #1;
    check("s3_read_da", 32'(data_available), 32'h1);
    tick(1);
    check("s3_ack", 32'(acknowledge), 32'h2);
    check("s3_da_after", 32'(data_available), 32'h0);

    // Reset pulse while acknowledge[1] is high; then link 0 beats link 3
    rst     = 1'b1;
    request = 4'b1001;
    #1;
    check("s4_rst_ack", 32'(acknowledge), 32'h0);
    check("s4_rst_da", 32'(data_available), 32'h0);
    check("s4_rst_sel", 32'(selected), 32'h0);
    check("s4_rst_terr", 32'(timeout_error), 32'h0);
    tick(1);
    rst = 1'b0;
    tick(2);
    check("s4_da_early", 32'(data_available), 32'h0);
    tick(1);
    check("s4_da", 32'(data_available), 32'h1);
    check("s4_sel", 32'(selected), 32'h0);
    tick(1);
    check("s4_ack", 32'(acknowledge), 32'h1);

    // Link 0 never releases its request
    do_reset();
    request       = 4'b0001;
    data_required = 1'b1;
    tick(4);
    check("s5_ack_high", 32'(acknowledge), 32'h1);
`ifdef HIGH_SPEED_IN_ARBITER_TIMEOUT_EN
    tick(7);
    check("s5_ack_before_to", 32'(acknowledge), 32'h1);
    check("s5_terr_before_to", 32'(timeout_error), 32'h0);
    tick(1);
    check("s5_ack_to", 32'(acknowledge), 32'h0);
    check("s5_terr_to", 32'(timeout_error), 32'h1);
    data_required = 1'b0;
    tick(5);
    check("s5_terr_sticky", 32'(timeout_error), 32'h1);
`else
    for (int i = 0; i < 10; i++) begin
      tick(10);
      check("s5_ack_stays", 32'(acknowledge), 32'h1);
      check("s5_terr_zero", 32'(timeout_error), 32'h0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/high_speed_in_arbiter.md
# high_speed_in_arbiter

Round-robin arbiter that shares one on-chip consumer between `NUM_CHANNELS` asynchronous 4-phase request/acknowledge input links. Each link's `request` is synchronized into `clk`. The arbiter selects one pending link and signals the consumer to read that link's data in a single cycle. It then acknowledges the link and waits for the handshake to close before serving the next link. It sits between the off-chip/async input ports and the core's single input FIFO/datapath.

## Interface
- `NUM_CHANNELS`, 4: number of async input links (≥2).
- `SEL_WIDTH`, `$clog2(NUM_CHANNELS)`: width of `selected`.
- `TIMEOUT_CYCLES`, 255: release-timeout limit, used only with the timeout feature.

Ports:
- `clk`  in  1: clock.
- `rst`  in  1: asynchronous, active-high reset.
- `data_required`  in  1: consumer can accept one word this cycle.
- `request`  in  `NUM_CHANNELS`: async per-link request (4-phase, level).
- `acknowledge`  out  `NUM_CHANNELS`: per-link acknowledge (registered, one-hot or zero).
- `data_available`  out  1: consumer reads the word of link `selected` in this cycle.
- `selected`  out  `SEL_WIDTH`: index of the granted link (registered).
- `timeout_error`  out  1: sticky release-timeout flag.

## Operation
- Each `request[i]` passes through a 2-flop synchronizer, giving `req_sync[i]`.
- FSM states: `IDLE`, `GRANT`, `RELEASE`.
- **IDLE**
  - If any `req_sync` bit is set, pick the first set bit searching from `last+1` upward, with wrap-around.
  - Register that index into `selected` and go to `GRANT`.
  - `data_required` is not needed to enter `GRANT`.
- **GRANT**
  - `data_available = data_required` (combinational from the state; this is the only state in which it can be high).
  - When `data_required` = 1: set `acknowledge[selected]` ← 1, set `last` ← `selected`, go to `RELEASE`.
  - Otherwise hold the current grant indefinitely; no re-arbitration occurs.
- **RELEASE**
  - When `req_sync[selected]` = 0: set `acknowledge[selected]` ← 0 and go to `IDLE`.
- At most one `acknowledge` bit is high at any time.
- A link never receives a second grant until its request has dropped and it has been re-arbitrated.
- A request that drops while its link is still pending in `IDLE` is simply not selected.
- A link whose request falls while it is in `GRANT` still completes the transfer; the protocol forbids this, and the arbiter does not check for it.
- Simultaneous requests are resolved by round-robin order only; no link can be starved beyond `NUM_CHANNELS-1` grants.

## Timing
- Reset values:
  - `acknowledge` = 0, `data_available` = 0, `selected` = 0, `timeout_error` = 0.
  - FSM = `IDLE`, `last` = `NUM_CHANNELS-1` (so link 0 has first priority).
  - Synchronizers cleared.
- Reset asserted mid-operation aborts the transaction immediately. All acknowledges drop asynchronously.
- Latency:
  - `request` rise to `req_sync`: 2 cycles.
  - `req_sync` to `GRANT` (`data_available` possible): +1 cycle.
  - Read cycle to `acknowledge` high: +1 cycle.
  - `request` fall to `acknowledge` low: 2 cycles (sync) + 1 cycle.
- Minimum spacing between two consumer reads: 1 (GRANT) + 1 (RELEASE) + 1 (IDLE) cycles, plus the link's release time.

## Configuration
- Macro: `HIGH_SPEED_IN_ARBITER_TIMEOUT_EN`.
- **Defined:**
  - A counter clears on entry to `RELEASE` and increments each `RELEASE` cycle.
  - On reaching `TIMEOUT_CYCLES` without `req_sync[selected]` falling: force `acknowledge` low, set `timeout_error` (sticky until `rst`), return to `IDLE`.
  - The offending link is then re-arbitrated like any other.
- **Undefined:** no counter; `RELEASE` waits forever; `timeout_error` is tied to 0.

## Structure
- Shared package `high_speed_in_pkg`: FSM state encoding (`ST_IDLE`, `ST_GRANT`, `ST_RELEASE`) and the default `TIMEOUT_CYCLES`.
- Sub-modules:
  - Existing `double_latching_barrier` (enable tied high), one instance per channel.
  - One new sub-module, `rr_priority_picker`: combinational; inputs are the request vector and `last`; outputs are `found` and `index`.

## Test plan
- Single link: `request[2]`=1 with `data_required`=1 → `data_available` 3 cycles later with `selected`=2 → `acknowledge[2]` next cycle → drop `request[2]` → `acknowledge[2]` low 3 cycles later.
- All four requests held, consumer always ready → grant order 0,1,2,3,0 with exactly one acknowledge high at a time.
- `data_required`=0 for 10 cycles while in `GRANT` → `selected` stable, `data_available`=0, no acknowledge; raise it → one read, then acknowledge.
- `rst` pulse while `acknowledge[1]`=1 → all outputs 0 immediately; after release, link 0 wins over link 3 when both are pending.
- With `HIGH_SPEED_IN_ARBITER_TIMEOUT_EN` and `TIMEOUT_CYCLES`=8, hold `request[0]` high after acknowledge → `acknowledge[0]` drops and `timeout_error`=1 after 8 `RELEASE` cycles; flag stays set.
- Without the macro, same stimulus → `acknowledge[0]` stays high and `timeout_error`=0 for 100 cycles.
